// File: rtl/trig_debounce_sync_nff.sv
// sync_nff: N-flop synchronizer for one asynchronous input.
//   Reusable for any async line feeding the edge detectors.
// Ports:
//   clk    - system clock (rising edge)
//   rst    - synchronous, active-high reset; clears every flop to 0
//   d      - raw asynchronous input, feeds flop 0 only
//   q      - synchronized output, taken from the last flop of the chain
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // Flop 0 is the only one that sees d; each later stage copies its
  // predecessor, so metastability has STAGES-1 clock periods to resolve.
  always_ff @(posedge clk) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], d};
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/trig_debounce.sv
// trig_debounce: synchronizes and debounces a raw asynchronous input into
//   a clean single-domain level for the toggle/edge detectors, and counts
//   aborted transitions (bounces) for diagnostics.
// Ports:
//   clk         - system clock, all logic on rising edge
//   rst         - synchronous, active-high reset (highest priority)
//   btn_in      - raw asynchronous input
//   bounce_clr  - synchronous clear of bounce_cnt (wins over an increment)
//   trigger     - debounced level, registered
//   busy        - high while a candidate transition is being qualified
//   bounce_cnt  - saturating count of aborted transitions
// Latency from the first edge that captures a new steady btn_in value to
// trigger changing: SYNC_STAGES + DEBOUNCE_CYCLES edges.
module trig_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BOUNCE_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_in,
  input  logic                bounce_clr,
  output logic                trigger,
  output logic                busy,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // Count of the final qualifying sample; the state changes on that sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BOUNCE_W-1:0] BOUNCE_MAX = '1;

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  logic                w_s;
  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_trig;
  logic                r_busy;
  logic [BOUNCE_W-1:0] r_bounce;

  sync_nff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (w_s)
  );

  // busy is registered alongside the next state rather than decoded from
  // r_state combinationally, so it is glitch-free at the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE_LOW;
      r_cnt    <= '0;
      r_trig   <= 1'b0;
      r_busy   <= 1'b0;
      r_bounce <= '0;
    end else begin
      case (r_state)
        IDLE_LOW: begin
          if (w_s) begin
            // The sample that leaves IDLE is qualifying sample 1.
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (w_s) begin
            if (r_cnt == CNT_LAST) begin
              r_state <= IDLE_HIGH;
              r_trig  <= 1'b1;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_state <= IDLE_LOW;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            if (r_bounce != BOUNCE_MAX) r_bounce <= r_bounce + BOUNCE_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!w_s) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
          end
        end
        default: begin // WAIT_LOW
          if (!w_s) begin
            if (r_cnt == CNT_LAST) begin
              r_state <= IDLE_LOW;
              r_trig  <= 1'b0;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_state <= IDLE_HIGH;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            if (r_bounce != BOUNCE_MAX) r_bounce <= r_bounce + BOUNCE_W'(1);
          end
        end
      endcase
      // Last assignment wins: a clear overrides an abort on the same edge.
      if (bounce_clr) r_bounce <= '0;
    end
  end

  assign trigger    = r_trig;
  assign busy       = r_busy;
  assign bounce_cnt = r_bounce;

endmodule

// File: tb/tb_trig_debounce.sv
module tb_trig_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int BW   = 8;
  localparam int BMAX = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_in = 1'b0;
  logic          bounce_clr = 1'b0;
  logic          trigger;
  logic          busy;
  logic [BW-1:0] bounce_cnt;

  int checks = 0;
  int errors = 0;

  trig_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .BOUNCE_W(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .bounce_clr (bounce_clr),
    .trigger    (trigger),
    .busy       (busy),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: s is btn_in delayed SYNC edges; the FSM is described
  // as "length of the current run of samples disagreeing with the output".
  logic [SYNC-1:0] m_sh;
  int              m_run;
  logic            m_trig;
  int              m_bc;

  task automatic model_step(input logic r, input logic b, input logic c);
    logic s;
    if (r) begin
      m_sh = '0; m_run = 0; m_trig = 1'b0; m_bc = 0;
    end else begin
      s = m_sh[SYNC-1];
      if (s != m_trig) begin
        m_run++;
        if (m_run == DEB) begin
          m_trig = s;
          m_run  = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0;
        if (m_bc < BMAX) m_bc++;
      end
      if (c) m_bc = 0;
      m_sh = {m_sh[SYNC-2:0], b};
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic b, input logic c);
    rst = r; btn_in = b; bounce_clr = c;
    @(posedge clk);
    model_step(r, b, c);
    #1;
  endtask

  typedef struct {
    logic r, b, c;
    logic t, bu;
    int   bc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic b, input logic c,
                              input logic t, input logic bu, input int bc);
    vec_t v;
    v.r = r; v.b = b; v.c = c; v.t = t; v.bu = bu; v.bc = bc;
    vecs.push_back(v);
  endfunction

  int toggles;
  logic prev_t;

  initial begin
    m_sh = '0; m_run = 0; m_trig = 1'b0; m_bc = 0;

    // 1. reset with btn high, then qualification from the first post-reset edge
    repeat (3) add(1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0);
    repeat (3) add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0); add(0, 1, 0, 1, 0, 0);
    // 4. release
    add(0, 0, 0, 1, 0, 0); add(0, 0, 0, 1, 0, 0);
    repeat (3) add(0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
    // 3. bounce: 2 cycles high
    add(0, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0); add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 1);
    // 5a. exactly 3 samples high -> abort
    repeat (2) add(0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1); add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 2); add(0, 0, 0, 0, 0, 2);
    // 5b. exactly 4 samples high -> accepted, then release completes
    repeat (2) add(0, 1, 0, 0, 0, 2);
    repeat (2) add(0, 1, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 1, 0, 2);
    repeat (3) add(0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 2); add(0, 0, 0, 0, 0, 2);
    // 6. reset at edge 4 of a press, then full re-qualification
    repeat (2) add(0, 1, 0, 0, 0, 2);
    add(0, 1, 0, 0, 1, 2);
    add(1, 1, 0, 0, 0, 0);
    repeat (2) add(0, 1, 0, 0, 0, 0);
    repeat (3) add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      tick(vecs[i].r, vecs[i].b, vecs[i].c);
      check($sformatf("vec%0d trigger", i), int'(trigger), int'(vecs[i].t));
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].bu));
      check($sformatf("vec%0d bounce_cnt", i), int'(bounce_cnt), vecs[i].bc);
    end

    // release fully, then saturate the bounce counter
    repeat (8) tick(0, 0, 0);
    check("released trigger", int'(trigger), 0);
    for (int k = 0; k < 300; k++) begin
      repeat (2) tick(0, 1, 0);
      repeat (4) tick(0, 0, 0);
    end
    check("bounce saturated", int'(bounce_cnt), BMAX);
    check("bounce sat trigger", int'(trigger), 0);

    // clear on the same edge as an abort: clear wins
    repeat (2) tick(0, 1, 0);
    repeat (2) tick(0, 0, 0);
    check("busy before abort", int'(busy), 1);
    tick(0, 0, 1);
    check("clr vs abort", int'(bounce_cnt), 0);
    check("clr vs abort busy", int'(busy), 0);
    tick(0, 0, 0);

    // one press/release yields exactly two trigger changes
    toggles = 0;
    prev_t  = trigger;
    for (int k = 0; k < 20; k++) begin
      tick(0, (k < 10) ? 1'b1 : 1'b0, 0);
      if (trigger != prev_t) toggles++;
      prev_t = trigger;
    end
    check("press/release toggles", toggles, 2);

    // randomized runs against the reference model
    for (int k = 0; k < 3000; k++) begin
      logic rb, rc, rr;
      int   len;
      rb  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * DEB + 2);
      for (int j = 0; j < len; j++) begin
        rc = ($urandom_range(0, 39) == 0);
        rr = ($urandom_range(0, 299) == 0);
        tick(rr, rb, rc);
        check("rand trigger", int'(trigger), int'(m_trig));
        check("rand busy", int'(busy), (m_run > 0) ? 1 : 0);
        check("rand bounce_cnt", int'(bounce_cnt), m_bc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
